// File: rtl/cond_pkg.sv
// Shared constants and helpers for the input conditioning blocks.
package cond_pkg;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;
   localparam int DEB_MAX  = 255;

   // Width of a counter that must hold values 0..cycles.
   function automatic int deb_cnt_w(int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// N-flop synchroniser with a loadable reset value; 1-bit in/out.
module sync_chain
   import cond_pkg::*;
#(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   generate
      if (N < SYNC_MIN || N > SYNC_MAX) begin : g_bad_n
         $error("sync_chain: N out of range");
      end
   endgenerate

   logic [N-1:0] s;

   // Shift the raw input through the chain; s[0] is the metastability catcher.
   always_ff @(posedge clk) begin
      if (rst) s <= {N{RST_VAL}};
      else     s <= {s[N-2:0], d};
   end

   assign q = s[N-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect one asynchronous input.
module input_conditioner
   import cond_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic en,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);

   generate
      if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
         $error("input_conditioner: SYNC_STAGES out of range");
      end
      if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > DEB_MAX) begin : g_bad_deb
         $error("input_conditioner: DEBOUNCE_CYCLES out of range");
      end
   endgenerate

   localparam int CW = deb_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s;
   logic [CW-1:0] cnt;

   sync_chain #(
      .N       (SYNC_STAGES),
      .RST_VAL (RESET_VAL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s)
   );

   // Count enabled mismatch cycles; commit the new level when the run completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= RESET_VAL;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (s == dout) begin
            cnt <= '0;
         end else if (en) begin
            if (cnt == CNT_LAST) begin
               dout <= s;
               cnt  <= '0;
               rise <= s;
               fall <= ~s;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   // A non-zero count means a level change is pending.
   assign busy = (cnt != '0);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a per-cycle reference model.
module tb_input_conditioner;

   localparam int   SYNC = 2;
   localparam int   DEB  = 4;
   localparam logic RV   = 1'b0;

   logic clk, rst, din, en;
   logic dout, rise, fall, busy;

   int tests = 0;
   int fails = 0;

   input_conditioner #(
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .RESET_VAL       (RV)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .en   (en),
      .dout (dout),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chki(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: s is din seen SYNC edges late; dout flips once the
   // mismatch has been seen on DEB enabled edges without interruption.
   logic [SYNC-1:0] m_hist;
   logic            m_dout, m_rise, m_fall;
   int              m_pend;
   bit              m_armed = 0;

   always @(posedge clk) begin
      automatic logic s_v = m_hist[SYNC-1];
      automatic logic d_v = m_dout;
      automatic int   p_v = m_pend;
      automatic logic r_v = 1'b0;
      automatic logic f_v = 1'b0;
      if (rst) begin
         m_hist  <= {SYNC{RV}};
         m_dout  <= RV;
         m_pend  <= 0;
         m_rise  <= 1'b0;
         m_fall  <= 1'b0;
         m_armed <= 1;
      end else begin
         if (s_v == d_v) p_v = 0;
         else if (en) begin
            p_v = p_v + 1;
            if (p_v == DEB) begin
               d_v = s_v; p_v = 0; r_v = s_v; f_v = !s_v;
            end
         end
         m_hist <= {m_hist[SYNC-2:0], din};
         m_dout <= d_v;
         m_pend <= p_v;
         m_rise <= r_v;
         m_fall <= f_v;
      end
   end

   // Compare every cycle once the first reset edge has happened.
   always @(negedge clk) begin
      if (m_armed) begin
         chk("dout", dout, m_dout);
         chk("rise", rise, m_rise);
         chk("fall", fall, m_fall);
         chk("busy", busy, m_pend != 0);
         chk("rise_fall_excl", rise & fall, 1'b0);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   int nr, nf, edge_at;
   bit saw_busy;

   initial begin
      rst = 1'b1; din = 1'b1; en = 1'b1;

      // 1. reset holds outputs low, then full latency after release
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t1_rst_dout", dout, 1'b0);
         chk("t1_rst_rise", rise, 1'b0);
         chk("t1_rst_busy", busy, 1'b0);
      end
      rst = 1'b0;
      nr = 0; edge_at = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (rise) begin nr++; edge_at = i; end
      end
      chki("t1_rise_count", nr, 1);
      chki("t1_rise_edge", edge_at, 6);
      chk("t1_dout", dout, 1'b1);

      // 3. clean fall
      din = 1'b0; nr = 0; nf = 0; edge_at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (fall) begin nf++; edge_at = i; end
         if (rise) nr++;
         if (i == 5) chk("t3_dout_pre", dout, 1'b1);
      end
      chki("t3_fall_count", nf, 1);
      chki("t3_fall_edge", edge_at, 6);
      chki("t3_rise_count", nr, 0);
      chk("t3_dout", dout, 1'b0);

      // 2. glitch of 3 cycles is rejected
      din = 1'b1; nr = 0; saw_busy = 0;
      for (int i = 1; i <= 13; i++) begin
         if (i == 4) din = 1'b0;
         tick();
         if (busy) saw_busy = 1;
         if (rise) nr++;
      end
      chk("t2_saw_busy", saw_busy, 1'b1);
      chk("t2_busy_end", busy, 1'b0);
      chki("t2_rise_count", nr, 0);
      chk("t2_dout", dout, 1'b0);

      // 4. bounce 1,0,1,0,1 then hold 1
      nr = 0; edge_at = 0;
      for (int i = 1; i <= 16; i++) begin
         din = (i <= 5) ? logic'(i % 2) : 1'b1;
         tick();
         if (rise) begin nr++; edge_at = i; end
      end
      chki("t4_rise_count", nr, 1);
      chki("t4_rise_edge", edge_at, 10);

      // 5. enable gating: en high on odd edges only
      din = 1'b0;
      repeat (8) tick();
      chk("t5_pre_dout", dout, 1'b0);
      din = 1'b1; nr = 0; edge_at = 0;
      for (int i = 1; i <= 14; i++) begin
         en = logic'(i % 2);
         tick();
         if (rise) begin nr++; edge_at = i; end
         if (i == 4) chk("t5_hold_busy", busy, 1'b1);
      end
      en = 1'b1;
      chki("t5_rise_count", nr, 1);
      chki("t5_rise_edge", edge_at, 9);

      // 6. reset mid-count discards pending rise
      din = 1'b0;
      repeat (8) tick();
      din = 1'b1;
      repeat (5) tick();
      chk("t6_busy_pending", busy, 1'b1);
      rst = 1'b1;
      tick();
      chk("t6_rst_dout", dout, 1'b0);
      chk("t6_rst_busy", busy, 1'b0);
      chk("t6_rst_rise", rise, 1'b0);
      rst = 1'b0; nr = 0; edge_at = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (rise) begin nr++; edge_at = i; end
      end
      chki("t6_rise_count", nr, 1);
      chki("t6_rise_edge", edge_at, 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
